// File: rtl/alu4bit_sweeper.sv
// Sequential initiator for a combinational 4-bit ALU: steps an opcode range over
// latched operands and streams each captured x/y result on a valid/ready port.
module alu4bit_sweeper #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic [3:0] first_op,
  input  logic [3:0] last_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [3:0] alu_x,
  input  logic [3:0] alu_y,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_opcode,
  output logic [3:0] res_x,
  output logic [3:0] res_y,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] SettleInit = 4'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StHold, StDone} state_e;

  state_e     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_last;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic [3:0] r_alu_opcode;
  logic [3:0] r_res_opcode;
  logic [3:0] r_res_x;
  logic [3:0] r_res_y;
  logic       r_res_valid;
  logic       r_busy;
  logic       r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cnt        <= 4'd0;
      r_last       <= 4'd0;
      r_alu_a      <= 4'd0;
      r_alu_b      <= 4'd0;
      r_alu_opcode <= 4'd0;
      r_res_opcode <= 4'd0;
      r_res_x      <= 4'd0;
      r_res_y      <= 4'd0;
      r_res_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else if (abort && (r_state != StIdle)) begin
      // Abort drops any pending result and never lets done fire.
      r_state     <= StIdle;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start && !abort) begin
            r_alu_a      <= a_in;
            r_alu_b      <= b_in;
            r_alu_opcode <= first_op;
            r_last       <= last_op;
            r_cnt        <= SettleInit;
            r_busy       <= 1'b1;
            r_state      <= StSettle;
          end
        end
        StSettle: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_res_x      <= alu_x;
            r_res_y      <= alu_y;
            r_res_opcode <= r_alu_opcode;
            r_res_valid  <= 1'b1;
            r_state      <= StHold;
          end
        end
        StHold: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            if (r_alu_opcode == r_last) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_alu_opcode <= r_alu_opcode + 4'd1;
              r_cnt        <= SettleInit;
              r_state      <= StSettle;
            end
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_opcode;
  assign res_valid  = r_res_valid;
  assign res_opcode = r_res_opcode;
  assign res_x      = r_res_x;
  assign res_y      = r_res_y;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_alu4bit_sweeper.sv
// Bench for alu4bit_sweeper: two instances (SETTLE=1 and SETTLE=3) share stimulus,
// each driving a behavioural 4-bit ALU; results are checked against a range model.
module tb_alu4bit_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, res_ready, sel;
  logic [3:0] a_in, b_in, first_op, last_op;

  logic [3:0] a1, b1, op1, x1, y1, ro1, rx1, ry1;
  logic       v1, bz1, d1;
  logic [3:0] a3, b3, op3, x3, y3, ro3, rx3, ry3;
  logic       v3, bz3, d3;

  logic start1, start3;
  assign start1 = start & ~sel;
  assign start3 = start & sel;

  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] op);
    logic [3:0] x, y;
    case (op)
      4'd0:    x = a + b;
      4'd1:    x = a - b;
      4'd2:    x = a & b;
      4'd3:    x = a | b;
      4'd4:    x = a ^ b;
      4'd5:    x = ~a;
      4'd6:    x = {a[2:0], 1'b0};
      4'd7:    x = {1'b0, a[3:1]};
      4'd8:    x = b - a;
      4'd9:    x = a + 4'd1;
      4'd10:   x = ~(a & b);
      4'd11:   x = ~(a | b);
      4'd12:   x = {a[2:0], a[3]};
      4'd13:   x = {a[0], a[3:1]};
      4'd14:   x = a ^ ~b;
      default: x = b;
    endcase
    y = (a + op) ^ b;
    return {x, y};
  endfunction

  assign {x1, y1} = alu_f(a1, b1, op1);
  assign {x3, y3} = alu_f(a3, b3, op3);

  alu4bit_sweeper #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .a_in(a_in), .b_in(b_in), .first_op(first_op), .last_op(last_op),
    .alu_a(a1), .alu_b(b1), .alu_opcode(op1), .alu_x(x1), .alu_y(y1),
    .res_valid(v1), .res_ready(res_ready), .res_opcode(ro1), .res_x(rx1), .res_y(ry1),
    .busy(bz1), .done(d1)
  );

  alu4bit_sweeper #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort),
    .a_in(a_in), .b_in(b_in), .first_op(first_op), .last_op(last_op),
    .alu_a(a3), .alu_b(b3), .alu_opcode(op3), .alu_x(x3), .alu_y(y3),
    .res_valid(v3), .res_ready(res_ready), .res_opcode(ro3), .res_x(rx3), .res_y(ry3),
    .busy(bz3), .done(d3)
  );

  logic [3:0] o_a, o_b, o_op, o_ro, o_rx, o_ry;
  logic       o_v, o_bz, o_d;
  assign o_a  = sel ? a3  : a1;
  assign o_b  = sel ? b3  : b1;
  assign o_op = sel ? op3 : op1;
  assign o_ro = sel ? ro3 : ro1;
  assign o_rx = sel ? rx3 : rx1;
  assign o_ry = sel ? ry3 : ry1;
  assign o_v  = sel ? v3  : v1;
  assign o_bz = sel ? bz3 : bz1;
  assign o_d  = sel ? d3  : d1;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alu_a"}, o_a, 0);
    chk({tag, "_alu_b"}, o_b, 0);
    chk({tag, "_alu_op"}, o_op, 0);
    chk({tag, "_res_op"}, o_ro, 0);
    chk({tag, "_res_x"}, o_rx, 0);
    chk({tag, "_res_y"}, o_ry, 0);
    chk({tag, "_valid"}, o_v, 0);
    chk({tag, "_busy"}, o_bz, 0);
    chk({tag, "_done"}, o_d, 0);
  endtask

  // One sweep on the selected instance. stall_k/mid_k/abort_k pick the result index at
  // which to apply backpressure, a busy-time start, or an abort (-1 disables each).
  task automatic run_sweep(input logic [3:0] a, input logic [3:0] b, input logic [3:0] f,
                           input logic [3:0] l, input int stall_k, input int stall_len,
                           input int mid_k, input int abort_k);
    int         s, n, extra, w, exp_edge;
    logic [3:0] op;
    logic [7:0] e;
    s     = sel ? 3 : 1;
    n     = ((int'(l) - int'(f) + 16) % 16) + 1;
    extra = 0;
    a_in = a; b_in = b; first_op = f; last_op = l; start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    edge_n = 0;
    chk("busy_at_e0", o_bz, 1);
    for (int k = 0; k < n; k++) begin
      op       = 4'(int'(f) + k);
      e        = alu_f(a, b, op);
      exp_edge = k * (s + 1) + s + extra;
      w = 0;
      while (!o_v && w < 100) begin
        tick();
        w++;
      end
      chk("valid_edge", edge_n, exp_edge);
      chk("res_opcode", o_ro, op);
      chk("res_x", o_rx, e[7:4]);
      chk("res_y", o_ry, e[3:0]);
      chk("alu_a_const", o_a, a);
      chk("alu_b_const", o_b, b);
      chk("busy_mid", o_bz, 1);
      chk("done_early", o_d, 0);
      if (k == abort_k) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", o_bz, 0);
        chk("abort_valid", o_v, 0);
        chk("abort_done", o_d, 0);
        repeat (3) begin
          tick();
          chk("abort_no_done", o_d, 0);
          chk("abort_idle", o_bz, 0);
        end
        return;
      end
      if (k == mid_k) begin
        res_ready = 1'b0;
        a_in = ~a; b_in = ~b; first_op = op + 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        extra++;
        chk("midstart_alu_a", o_a, a);
        chk("midstart_alu_b", o_b, b);
        chk("midstart_alu_op", o_op, op);
        chk("midstart_valid", o_v, 1);
        res_ready = 1'b1;
      end
      if (k == stall_k) begin
        res_ready = 1'b0;
        repeat (stall_len) begin
          tick();
          extra++;
          chk("stall_valid", o_v, 1);
          chk("stall_res_op", o_ro, op);
          chk("stall_res_x", o_rx, e[7:4]);
          chk("stall_res_y", o_ry, e[3:0]);
          chk("stall_alu_op", o_op, op);
        end
        res_ready = 1'b1;
      end
      tick();
      chk("valid_drop", o_v, 0);
      if (k < n - 1) begin
        chk("next_opcode", o_op, 4'(op + 4'd1));
        chk("no_done_yet", o_d, 0);
      end else begin
        chk("done_pulse", o_d, 1);
        chk("done_edge", edge_n, n * (s + 1) + extra);
        tick();
        chk("done_once", o_d, 0);
        chk("busy_fall", o_bz, 0);
        chk("no_extra_valid", o_v, 0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_r, sk;
    logic [3:0] f_r, l_r;
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1; sel = 1'b0;
    a_in = 4'd0; b_in = 4'd0; first_op = 4'd0; last_op = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset1");
    sel = 1'b1;
    #1;
    chk_all_zero("reset3");
    rst = 1'b0;
    sel = 1'b0;

    // Full sweep, SETTLE=1: done lands on E0+32.
    run_sweep(4'b1010, 4'b0101, 4'd0, 4'd15, -1, 0, -1, -1);
    // Backpressure with SETTLE=3.
    sel = 1'b1;
    run_sweep(4'd3, 4'd9, 4'd2, 4'd6, 1, 5, -1, -1);
    // Wrap-around and single opcode on both instances.
    sel = 1'b0;
    run_sweep(4'd7, 4'd12, 4'd14, 4'd1, -1, 0, -1, -1);
    run_sweep(4'd5, 4'd6, 4'd7, 4'd7, -1, 0, -1, -1);
    sel = 1'b1;
    run_sweep(4'd11, 4'd2, 4'd14, 4'd1, -1, 0, -1, -1);
    run_sweep(4'd1, 4'd15, 4'd7, 4'd7, -1, 0, -1, -1);
    // Abort on the third result, then a clean sweep.
    run_sweep(4'd9, 4'd4, 4'd0, 4'd9, -1, 0, -1, 2);
    run_sweep(4'd9, 4'd4, 4'd0, 4'd9, -1, 0, -1, -1);
    sel = 1'b0;
    run_sweep(4'd6, 4'd8, 4'd3, 4'd12, -1, 0, -1, 2);
    run_sweep(4'd2, 4'd13, 4'd3, 4'd5, -1, 0, -1, -1);
    // Start while busy is ignored.
    run_sweep(4'd4, 4'd10, 4'd1, 4'd4, -1, 0, 1, -1);

    // Abort in idle blocks a simultaneous start.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_blocks_start", o_bz, 0);
    chk("idle_abort_no_valid", o_v, 0);

    // Reset mid-sweep.
    sel = 1'b1;
    a_in = 4'd13; b_in = 4'd7; first_op = 4'd5; last_op = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("pre_reset_busy", o_bz, 1);
    rst = 1'b1;
    tick();
    chk_all_zero("midreset");
    rst = 1'b0;
    run_sweep(4'd13, 4'd7, 4'd5, 4'd8, -1, 0, -1, -1);

    // Randomized sweeps with random backpressure.
    repeat (20) begin
      sel = 1'($urandom_range(0, 1));
      f_r = 4'($urandom_range(0, 15));
      l_r = 4'($urandom_range(0, 15));
      n_r = ((int'(l_r) - int'(f_r) + 16) % 16) + 1;
      sk  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n_r - 1)) : -1;
      run_sweep(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), f_r, l_r, sk,
                int'($urandom_range(1, 4)), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu4bit_sweeper.md
# alu4bit_sweeper

Sequential driver for the combinational `alu4bit`. It acts as the initiator end of the ALU's operand/opcode interface.

- On `start`, it latches a pair of 4-bit operands and an opcode range.
- It steps the ALU through every opcode in that range, holding each opcode for a settle interval.
- It captures the `x`/`y` results and presents each one on a valid/ready result port.
- It replaces testbench-driven opcode sweeps with a synthesizable unit, for on-chip self-test and result streaming.

## Interface

Parameters:
- `SETTLE`, default 1: number of clock cycles each opcode is held before the ALU outputs are captured. Legal range is 1..15.

Ports:
- `clk`, input, 1: single clock. All logic updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: sweep request. Sampled only in IDLE.
- `abort`, input, 1: cancels an in-progress sweep.
- `a_in`, input, 4: operand A, latched on start.
- `b_in`, input, 4: operand B, latched on start.
- `first_op`, input, 4: first opcode of the sweep, latched on start.
- `last_op`, input, 4: last opcode of the sweep (inclusive), latched on start.
- `alu_a`, output, 4: drives the ALU `a` input.
- `alu_b`, output, 4: drives the ALU `b` input.
- `alu_opcode`, output, 4: drives the ALU `opcode` input.
- `alu_x`, input, 4: ALU `x` result.
- `alu_y`, input, 4: ALU `y` result.
- `res_valid`, output, 1: a captured result is available.
- `res_ready`, input, 1: the consumer accepts the result.
- `res_opcode`, output, 4: opcode that produced the captured result.
- `res_x`, output, 4: captured `x`.
- `res_y`, output, 4: captured `y`.
- `busy`, output, 1: high whenever the FSM is not in IDLE.
- `done`, output, 1: one-cycle pulse when a sweep completes normally.

## Operation

States: IDLE, SETTLE, HOLD, DONE.

- **IDLE**, on `start && !abort`:
  - latch `a_in`→`alu_a`, `b_in`→`alu_b`, `first_op`→`alu_opcode`, `last_op`→internal `last`;
  - load settle counter `cnt <= SETTLE-1`;
  - go to SETTLE.
- **SETTLE**:
  - if `cnt != 0`, decrement `cnt`;
  - if `cnt == 0`, capture `res_x <= alu_x`, `res_y <= alu_y`, `res_opcode <= alu_opcode`, set `res_valid <= 1`, go to HOLD.
- **HOLD**: wait for `res_valid && res_ready`. On the accepting edge, `res_valid <= 0`, then:
  - if `alu_opcode == last`, go to DONE;
  - otherwise `alu_opcode <= alu_opcode + 1` (mod 16), `cnt <= SETTLE-1`, go to SETTLE.
- **DONE**: `done = 1` for this single cycle, then go to IDLE.

Range, wrap-around and stability rules:
- Number of results per sweep = ((`last_op` − `first_op`) mod 16) + 1, i.e. 1..16.
- `last_op < first_op` wraps through 15→0.
- `first_op == last_op` produces exactly one result.
- `alu_a` and `alu_b` are constant for the whole sweep.
- `alu_opcode` changes only on the HOLD→SETTLE edge.
- `res_*` are stable while `res_valid` is high.

Control-input rules:
- `start` is ignored outside IDLE.
- `abort` in SETTLE, HOLD or DONE returns the FSM to IDLE on the next edge, clears `res_valid`, and suppresses `done`.
- `abort` in IDLE has no effect, and it blocks a simultaneous `start`.
- `res_ready` may be high before `res_valid`; this is legal.

Reset values:
- `rst` has priority over everything and may be asserted mid-sweep.
- All outputs reset to 0: `alu_a`, `alu_b`, `alu_opcode`, `res_opcode`, `res_x`, `res_y`, `res_valid`, `busy`, `done`.
- FSM resets to IDLE; `cnt` resets to 0.

## Timing

- Let E0 be the edge that samples `start`. `busy` is high from E0.
- `res_valid` for the first result rises at edge E0+SETTLE.
- With `res_ready` held high, each result costs SETTLE+1 cycles: settle, then one valid cycle.
- Result k (0-based) becomes valid at edge E0 + k·(SETTLE+1) + SETTLE.
- After the final accept edge, `done` is high for exactly one cycle. `busy` falls one edge later.
- With SETTLE=1 and 16 opcodes, `done` is high between E0+32 and E0+33.
- Under backpressure, the FSM stays in HOLD indefinitely with no timeout.
- ALU outputs are assumed combinational. The capture edge is at least SETTLE cycles after the last `alu_*` change.

## Test plan

- **Full sweep.** Stimulus: SETTLE=1, `a_in=4'b1010`, `b_in=4'b0101`, `first_op=0`, `last_op=15`, `res_ready=1`, real `alu4bit` attached. Required: 16 results with `res_opcode` 0..15 in order, `res_x`/`res_y` matching a reference model, one `done` pulse at E0+32, `busy` low at E0+33.
- **Backpressure.** Stimulus: SETTLE=3; drop `res_ready` for 5 cycles while `res_valid` is high. Required: `res_*` and `alu_opcode` hold constant, no result is lost or duplicated, and the next opcode starts on the accept edge.
- **Wrap-around.** Stimulus: `first_op=14`, `last_op=1`. Required: exactly 4 results with opcodes 14, 15, 0, 1, then `done`.
- **Single opcode.** Stimulus: `first_op=last_op=7`. Required: exactly one result with opcode 7, valid at E0+SETTLE, then `done`.
- **Abort mid-sweep.** Stimulus: assert `abort` while the third result is pending. Required: `busy` and `res_valid` are 0 after the next edge, no `done` pulse, and a following `start` runs a clean sweep.
- **Start while busy, and reset mid-sweep.** Stimulus: pulse `start` with different operands mid-sweep, then assert `rst` mid-sweep. Required: the mid-sweep `start` has no effect on `alu_a`/`alu_b`/`alu_opcode`; after `rst`, all outputs are 0 on the next edge.
